// File: rtl/aurora_rx_frame_unpack_if.sv
// Aurora RX user stream as delivered by the RX core: data, valid, last and byte keep.
// There is no ready signal; the sink must accept every valid beat.
`timescale 1ns / 1ps
interface aurora_rx_frame_unpack_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   rx_data;
  logic                    rx_valid;
  logic                    rx_last;
  logic [DATA_WIDTH/8-1:0] rx_keep;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_last,
    output rx_keep
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input rx_last,
    input rx_keep
  );
endinterface

// File: rtl/aurora_rx_frame_unpack.sv
// Reassembles fixed 3-word Aurora RX frames into word_1..word_3 and flags/counts
// short, long and partial-keep frames with saturating counters.
`timescale 1ns / 1ps
module aurora_rx_frame_unpack #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  aurora_rx_frame_unpack_if.slave    rx,
  output logic [DATA_WIDTH-1:0]      word_1,
  output logic [DATA_WIDTH-1:0]      word_2,
  output logic [DATA_WIDTH-1:0]      word_3,
  output logic                       frame_valid,
  output logic                       frame_err,
  output logic [CNT_WIDTH-1:0]       frame_count,
  output logic [CNT_WIDTH-1:0]       err_count
);

  typedef enum logic [1:0] {StIdle, StGot1, StGot2, StDrop} state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] s1_q, s2_q;
  logic                  keep_bad_q, keep_bad_d;
  logic                  keep_bad_now;
  logic                  good_term, err_term;

  // Sticky keep error must include the beat being sampled right now.
  assign keep_bad_now = keep_bad_q | ~(&rx.rx_keep);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rx.rx_valid) begin
      unique case (state_q)
        StIdle:  state_d = rx.rx_last ? StIdle : StGot1;
        StGot1:  state_d = rx.rx_last ? StIdle : StGot2;
        StGot2:  state_d = rx.rx_last ? StIdle : StDrop;
        StDrop:  state_d = rx.rx_last ? StIdle : StDrop;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    good_term  = 1'b0;
    err_term   = 1'b0;
    keep_bad_d = keep_bad_q;
    if (rx.rx_valid) begin
      keep_bad_d = rx.rx_last ? 1'b0 : keep_bad_now;
      if (rx.rx_last) begin
        good_term = (state_q == StGot2) && !keep_bad_now;
        err_term  = !good_term;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      keep_bad_q  <= 1'b0;
      word_1      <= '0;
      word_2      <= '0;
      word_3      <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      keep_bad_q  <= keep_bad_d;
      frame_valid <= good_term;
      frame_err   <= err_term;
      if (rx.rx_valid && (state_q == StIdle)) begin
        s1_q <= rx.rx_data;
      end
      if (rx.rx_valid && (state_q == StGot1)) begin
        s2_q <= rx.rx_data;
      end
      if (good_term) begin
        word_1 <= s1_q;
        word_2 <= s2_q;
        word_3 <= rx.rx_data;
        if (frame_count != '1) begin
          frame_count <= frame_count + 1'b1;
        end
      end
      if (err_term && (err_count != '1)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aurora_rx_frame_unpack.sv
// Directed bench for aurora_rx_frame_unpack; a second instance with 2-bit counters
// shares the stream to exercise counter saturation.
`timescale 1ns / 1ps
module tb_aurora_rx_frame_unpack;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  aurora_rx_frame_unpack_if #(.DATA_WIDTH(DW)) rx ();

  logic [DW-1:0] word_1, word_2, word_3;
  logic          frame_valid, frame_err;
  logic [15:0]   frame_count, err_count;

  logic [DW-1:0] sat_w1, sat_w2, sat_w3;
  logic          sat_fv, sat_fe;
  logic [1:0]    sat_fc, sat_ec;

  aurora_rx_frame_unpack #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .word_1      (word_1),
    .word_2      (word_2),
    .word_3      (word_3),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .frame_count (frame_count),
    .err_count   (err_count)
  );

  aurora_rx_frame_unpack #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_sat (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .word_1      (sat_w1),
    .word_2      (sat_w2),
    .word_3      (sat_w3),
    .frame_valid (sat_fv),
    .frame_err   (sat_fe),
    .frame_count (sat_fc),
    .err_count   (sat_ec)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one beat for the next rising edge; returns at the following falling edge.
  task automatic beat(input logic [31:0] d, input logic l, input logic [3:0] k);
    rx.rx_data  = d;
    rx.rx_valid = 1'b1;
    rx.rx_last  = l;
    rx.rx_keep  = k;
    @(negedge clk);
    rx.rx_valid = 1'b0;
    rx.rx_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic frame3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    beat(a, 1'b0, 4'hF);
    beat(b, 1'b0, 4'hF);
    beat(c, 1'b1, 4'hF);
  endtask

  initial begin
    rx.rx_data  = '0;
    rx.rx_valid = 1'b0;
    rx.rx_last  = 1'b0;
    rx.rx_keep  = 4'hF;
    reset       = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_w1", word_1, 32'h0);
    chk("rst_w2", word_2, 32'h0);
    chk("rst_w3", word_3, 32'h0);
    chk("rst_fv", {31'b0, frame_valid}, 32'h0);
    chk("rst_fe", {31'b0, frame_err}, 32'h0);
    chk("rst_fc", {16'b0, frame_count}, 32'h0);
    chk("rst_ec", {16'b0, err_count}, 32'h0);
    reset = 1'b1;
    idle(1);

    // 1: basic good frame
    frame3(32'hdeadbeef, 32'hcafebabe, 32'h19900614);
    chk("t1_fv", {31'b0, frame_valid}, 32'h1);
    chk("t1_fe", {31'b0, frame_err}, 32'h0);
    chk("t1_w1", word_1, 32'hdeadbeef);
    chk("t1_w2", word_2, 32'hcafebabe);
    chk("t1_w3", word_3, 32'h19900614);
    chk("t1_fc", {16'b0, frame_count}, 32'h1);
    chk("t1_ec", {16'b0, err_count}, 32'h0);
    idle(1);
    chk("t1_fv_off", {31'b0, frame_valid}, 32'h0);

    // 2: gaps inside a frame, then a back-to-back frame
    do_reset();
    beat(32'hdeadbeef, 1'b0, 4'hF);
    idle(2);
    beat(32'hcafebabe, 1'b0, 4'hF);
    idle(2);
    beat(32'h19900614, 1'b1, 4'hF);
    chk("t2_fv_a", {31'b0, frame_valid}, 32'h1);
    chk("t2_w3_a", word_3, 32'h19900614);
    beat(32'h12345678, 1'b0, 4'hF);
    chk("t2_fv_gap", {31'b0, frame_valid}, 32'h0);
    beat(32'h98765432, 1'b0, 4'hF);
    beat(32'habcdef01, 1'b1, 4'hF);
    chk("t2_fv_b", {31'b0, frame_valid}, 32'h1);
    chk("t2_w1", word_1, 32'h12345678);
    chk("t2_w2", word_2, 32'h98765432);
    chk("t2_w3", word_3, 32'habcdef01);
    chk("t2_fc", {16'b0, frame_count}, 32'h2);
    idle(1);

    // 3: short frame, then a normal frame
    beat(32'h11111111, 1'b0, 4'hF);
    beat(32'h22222222, 1'b1, 4'hF);
    chk("t3_fe", {31'b0, frame_err}, 32'h1);
    chk("t3_fv", {31'b0, frame_valid}, 32'h0);
    chk("t3_ec", {16'b0, err_count}, 32'h1);
    chk("t3_w1", word_1, 32'h12345678);
    chk("t3_w3", word_3, 32'habcdef01);
    idle(1);
    chk("t3_fe_off", {31'b0, frame_err}, 32'h0);
    frame3(32'h33333333, 32'h44444444, 32'h55555555);
    chk("t3_fv_next", {31'b0, frame_valid}, 32'h1);
    chk("t3_w1_next", word_1, 32'h33333333);
    chk("t3_fc", {16'b0, frame_count}, 32'h3);
    idle(1);

    // 4: long frame of five beats
    for (int i = 0; i < 4; i++) begin
      beat(32'ha0a0a0a0 + i, 1'b0, 4'hF);
      chk("t4_fe_mid", {31'b0, frame_err}, 32'h0);
    end
    beat(32'ha0a0a0a4, 1'b1, 4'hF);
    chk("t4_fe", {31'b0, frame_err}, 32'h1);
    chk("t4_fv", {31'b0, frame_valid}, 32'h0);
    chk("t4_ec", {16'b0, err_count}, 32'h2);
    chk("t4_w2", word_2, 32'h44444444);
    idle(1);
    chk("t4_fe_off", {31'b0, frame_err}, 32'h0);
    chk("t4_ec_hold", {16'b0, err_count}, 32'h2);

    // 5: partial keep on beat 2, then a clean frame
    beat(32'h66666666, 1'b0, 4'hF);
    beat(32'h77777777, 1'b0, 4'h7);
    beat(32'h88888888, 1'b1, 4'hF);
    chk("t5_fe", {31'b0, frame_err}, 32'h1);
    chk("t5_fv", {31'b0, frame_valid}, 32'h0);
    chk("t5_ec", {16'b0, err_count}, 32'h3);
    chk("t5_w3", word_3, 32'h55555555);
    idle(1);
    frame3(32'h99999999, 32'haaaaaaaa, 32'hbbbbbbbb);
    chk("t5_fv_next", {31'b0, frame_valid}, 32'h1);
    chk("t5_fe_next", {31'b0, frame_err}, 32'h0);
    chk("t5_w1", word_1, 32'h99999999);
    chk("t5_w3_next", word_3, 32'hbbbbbbbb);
    chk("t5_fc", {16'b0, frame_count}, 32'h4);
    chk("t5_sat_fc", {30'b0, sat_fc}, 32'h3);
    chk("t5_sat_ec", {30'b0, sat_ec}, 32'h3);
    idle(1);

    // 6: reset mid-frame with a valid beat on the reset edge
    beat(32'hc1c1c1c1, 1'b0, 4'hF);
    beat(32'hc2c2c2c2, 1'b0, 4'hF);
    rx.rx_data  = 32'hdddddddd;
    rx.rx_valid = 1'b1;
    rx.rx_last  = 1'b0;
    rx.rx_keep  = 4'hF;
    do_reset();
    rx.rx_valid = 1'b0;
    chk("t6_rst_fc", {16'b0, frame_count}, 32'h0);
    chk("t6_rst_ec", {16'b0, err_count}, 32'h0);
    beat(32'hc3c3c3c3, 1'b1, 4'hF);
    chk("t6_fe", {31'b0, frame_err}, 32'h1);
    chk("t6_ec", {16'b0, err_count}, 32'h1);
    chk("t6_fc", {16'b0, frame_count}, 32'h0);
    chk("t6_w1", word_1, 32'h0);
    chk("t6_w2", word_2, 32'h0);
    chk("t6_w3", word_3, 32'h0);
    for (int i = 0; i < 4; i++) begin
      frame3(32'h10000000 + i, 32'h20000000 + i, 32'h30000000 + i);
    end
    chk("t6_fc_main", {16'b0, frame_count}, 32'h4);
    chk("t6_sat_fc", {30'b0, sat_fc}, 32'h3);
    chk("t6_sat_ec", {30'b0, sat_ec}, 32'h1);
    chk("t6_sat_w3", sat_w3, 32'h30000003);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
